// File: rtl/k2_arb_pkg.sv
// Shared types and constants for the k2 data-RAM arbiter.
package k2_arb_pkg;

  localparam int unsigned K2_RAM_AW = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/k2_wait_counter.sv
// Saturating count of consecutive denied host cycles; terminal marks a forced slot.
module k2_wait_counter #(
  parameter  int unsigned MAX_WAIT = 4,
  localparam int unsigned CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic terminal
);

  logic [CW-1:0] count;

  assign terminal = (count == CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/k2_mem_arbiter.sv
// Single-port data-RAM arbiter: core has fixed priority, host gets a forced
// slot after MAX_WAIT consecutive denials so it cannot starve.
module k2_mem_arbiter
  import k2_arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned AW       = K2_RAM_AW,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_valid,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [N-1:0]  core_wdata,
  output logic [N-1:0]  core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [N-1:0]  host_wdata,
  output logic          host_ack,
  output logic [N-1:0]  host_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [N-1:0]  ram_wdata,
  input  logic [N-1:0]  ram_rdata
);

  arb_state_t state;
  owner_t     owner;
  logic       terminal;
  logic       wait_inc;
  logic       wait_clr;

  always_comb begin
    owner = OWN_NONE;
    if (state == IDLE && host_req && (!core_valid || terminal)) begin
      owner = OWN_HOST;
    end else if (core_valid) begin
      owner = OWN_CORE;
    end
  end

  assign core_stall = core_valid && (owner == OWN_HOST);
  assign core_rdata = ram_rdata;
  // The ack is a registered state, so mask it combinationally during reset.
  assign host_ack   = (state == ACK) && !reset;

  always_comb begin
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    ram_we    = 1'b0;
    unique case (owner)
      OWN_CORE: ram_we = core_we;
      OWN_HOST: begin
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        ram_we    = host_we;
      end
      default: ram_we = 1'b0;
    endcase
  end

  assign wait_inc = (state == IDLE) && host_req && (owner != OWN_HOST);
  assign wait_clr = (owner == OWN_HOST) || !host_req;

  k2_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      host_rdata <= '0;
    end else begin
      state <= (owner == OWN_HOST) ? ACK : IDLE;
      if (owner == OWN_HOST) begin
        host_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_k2_mem_arbiter.sv
// Bench for k2_mem_arbiter: external RAM model, scoreboard of host read data.
module tb_k2_mem_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_valid;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [N-1:0]  core_wdata;
  logic [N-1:0]  core_rdata;
  logic          core_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [N-1:0]  host_wdata;
  logic          host_ack;
  logic [N-1:0]  host_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [N-1:0]  ram_wdata;
  logic [N-1:0]  ram_rdata;

  logic          ram_clr;
  logic [N-1:0]  mem [32];

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] sb [$];

  always #5 clk = ~clk;

  k2_mem_arbiter #(
    .N        (N),
    .AW       (AW),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_valid (core_valid),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // RAM macro model: asynchronous read, synchronous write.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (host_ack === 1'b1) begin
      if (sb.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
      else check("host_rdata", 32'(host_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic host_txn(input logic we, input logic [AW-1:0] a, input logic [N-1:0] d,
                          input logic [N-1:0] exp, input int lat_exp, input string tag);
    int lat;
    lat = 99;
    sb.push_back(exp);
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      smp();
      if (host_ack) begin
        lat = i;
        host_req = 1'b0;
        break;
      end
      tick();
    end
    host_req = 1'b0;
    check(tag, 32'(lat), 32'(lat_exp));
    tick();
  endtask

  initial begin
    reset = 1'b1; ram_clr = 1'b1;
    core_valid = 1'b1; core_we = 1'b0; core_addr = 5'd9; core_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd1; host_wdata = 8'h00;
    tick();
    for (int c = 0; c < 2; c++) begin
      smp();
      check("rst_ack", 32'(host_ack), 32'd0);
      check("rst_rdata", 32'(host_rdata), 32'd0);
      tick();
    end
    reset = 1'b0; ram_clr = 1'b0;
    smp();
    check("post_rst_stall", 32'(core_stall), 32'd0);
    check("post_rst_addr", 32'(ram_addr), 32'd9);
    tick();
    host_req = 1'b0; core_valid = 1'b0;
    tick();

    // Host alone: grant in the request cycle, ack one cycle later.
    host_we = 1'b1; host_addr = 5'd5; host_wdata = 8'hA5; host_req = 1'b1;
    smp();
    check("hw_ram_we", 32'(ram_we), 32'd1);
    check("hw_ram_addr", 32'(ram_addr), 32'd5);
    check("hw_ram_wdata", 32'(ram_wdata), 32'hA5);
    host_req = 1'b0;
    host_txn(1'b1, 5'd5, 8'hA5, 8'h00, 1, "hw_lat");
    host_txn(1'b0, 5'd5, 8'h00, 8'hA5, 1, "hr_lat");

    // Core busy: host forced in after four denials; core write to 3 suppressed.
    sb.push_back(8'hA5);
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd5;
    core_valid = 1'b1; core_we = 1'b0; core_addr = 5'd10;
    for (int c = 0; c < 4; c++) begin
      smp();
      check("deny_stall", 32'(core_stall), 32'd0);
      check("deny_addr", 32'(ram_addr), 32'd10);
      tick();
    end
    core_we = 1'b1; core_addr = 5'd3; core_wdata = 8'hEE;
    smp();
    check("force_stall", 32'(core_stall), 32'd1);
    check("force_addr", 32'(ram_addr), 32'd5);
    check("force_we", 32'(ram_we), 32'd0);
    tick();
    core_we = 1'b0; host_req = 1'b0;
    smp();
    check("force_ack", 32'(host_ack), 32'd1);
    check("ack_stall", 32'(core_stall), 32'd0);
    check("addr3_kept", 32'(core_rdata), 32'd0);
    tick();

    // Core write then combinational read-back.
    core_we = 1'b1; core_addr = 5'd7; core_wdata = 8'h3C;
    smp();
    check("cw_we", 32'(ram_we), 32'd1);
    check("cw_addr", 32'(ram_addr), 32'd7);
    check("cw_wdata", 32'(ram_wdata), 32'h3C);
    tick();
    core_we = 1'b0;
    smp();
    check("cr_data", 32'(core_rdata), 32'h3C);
    tick();

    // Host abandons after two denials; a new request needs four fresh denials.
    core_addr = 5'd10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd12; host_wdata = 8'h77;
    for (int c = 0; c < 2; c++) begin
      smp();
      check("abandon_stall", 32'(core_stall), 32'd0);
      check("abandon_we", 32'(ram_we), 32'd0);
      tick();
    end
    host_req = 1'b0;
    smp();
    check("drop_ack", 32'(host_ack), 32'd0);
    tick();
    host_txn(1'b0, 5'd12, 8'h00, 8'h00, 5, "rereq_lat");
    core_addr = 5'd12;
    smp();
    check("addr12_kept", 32'(core_rdata), 32'd0);
    tick();

    // Reset landing on the ACK cycle drops the ack.
    core_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd7;
    smp();
    check("pre_rst_grant", 32'(ram_addr), 32'd7);
    tick();
    reset = 1'b1; host_req = 1'b0; core_valid = 1'b1; core_addr = 5'd9;
    smp();
    check("rst_in_ack", 32'(host_ack), 32'd0);
    tick();
    reset = 1'b0; host_req = 1'b1;
    smp();
    check("rel_ack", 32'(host_ack), 32'd0);
    check("rel_stall", 32'(core_stall), 32'd0);
    check("rel_addr", 32'(ram_addr), 32'd9);
    check("rel_rdata", 32'(host_rdata), 32'd0);
    tick();
    host_req = 1'b0; core_valid = 1'b0;
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
